array_west_feeder: RTL and testbench
====================================

ARRAY_WEST_FEEDER -- requirements
Module: array_west_feeder

Interface
REQ-001 SHALL have parameters: bw, 4, activation/kernel element width; row, 8, array rows driven; col, 8, columns per row (kernel-load beats); depth, 16, vector FIFO entries (power of 2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push one row vector.
- wr_data  in  row*bw  vector; slice r feeds array row r.
- full  out  1  FIFO full.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  1  0 = kernel load, 1 = execute.
- cmd_len  in  8  execute beat count; ignored for load.
- out_w  out  row*bw  per-row data to array west edge (tile in_w).
- inst_out  out  row*2  per-row instruction (bit0 kernel load, bit1 execute).
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.

Function
REQ-003 FIFO: depth entries of row*bw bits, registered read, no write-to-read bypass; write while full SHALL be dropped, no state change.
REQ-004 full SHALL equal (count == depth); pointers wrap modulo depth; simultaneous push and pop when neither full nor empty SHALL keep count unchanged.
REQ-005 FSM states IDLE, LOAD, EXEC, DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-006 IDLE -> LOAD on accepted op 0; IDLE -> EXEC on accepted op 1 with cmd_len>0; accepted op 1 with cmd_len==0 SHALL stay IDLE and pulse done the next cycle.
REQ-007 LOAD SHALL issue exactly col beats, beat k carrying the kernel for column k (first beat latched by column 0), inst bits 01.
REQ-008 EXEC SHALL issue exactly cmd_len beats, inst bits 10.
REQ-009 A beat SHALL pop one FIFO entry; if FIFO empty in LOAD/EXEC the cycle SHALL be a bubble: inst 00, out_w held, beat counter unchanged.
REQ-010 After the final beat FSM SHALL enter DRAIN for row-1 cycles (skew flush; 0 cycles if row==1 or skew disabled), then IDLE with done high for one cycle.
REQ-011 Non-skewed row-0 output latency SHALL be one cycle from FIFO pop to out_w/inst_out.
REQ-012 busy SHALL be high in LOAD, EXEC, DRAIN.
REQ-013 wr_en SHALL be accepted in every state including DRAIN.

Reset
REQ-014 Reset low SHALL immediately clear FIFO pointers/count, FSM to IDLE, beat counter, skew registers; out_w=0, inst_out=0, busy=0, done=0, full=0, cmd_ready=1.
REQ-015 Reset mid-command SHALL abort without a done pulse; no partial beat SHALL emerge after release.

Configuration
REQ-016 With FEEDER_SKEW_EN defined, row r data and inst SHALL be delayed r additional cycles by a per-row shift register.
REQ-017 Without FEEDER_SKEW_EN, all rows SHALL be aligned (row-0 timing) and DRAIN SHALL be skipped.

Structure
REQ-018 Shared package SHALL hold inst encodings (INST_IDLE=00, INST_LOAD=01, INST_EXEC=10) and FSM state typedef.
REQ-019 The FIFO SHALL be a separate sub-module, vec_fifo.

Verification
REQ-020 Reset, push 8 vectors, load cmd -> 8 consecutive beats inst 01 on row 0 starting 1 cycle after acceptance, row 7 starting 8 cycles after, done 7 cycles after last row-0 beat (skew on).
REQ-021 Exec cmd_len=3, FIFO holds 1 entry, 2 pushed 4 cycles later -> row 0: beat, bubbles (inst 00), 2 beats; exactly 3 inst 10 beats per row.
REQ-022 Push 17 vectors, no reads -> full after 16th, 17th dropped; later 16 pops return entries 1..16 in order.
REQ-023 Exec cmd_len=0 -> no beats, busy stays 0, done pulses next cycle.
REQ-024 Reset low mid-EXEC at beat 2 of 5 -> all outputs 0 same cycle, no done, FIFO empty after release.
REQ-025 Skew off: load cmd -> all 8 rows show identical inst timing, done right after last beat.

Source files
------------

// File: rtl/array_west_feeder_pkg.sv
// Shared encodings for the systolic-array west-edge feeder.
// Holds the per-row instruction codes and the feeder FSM state type.
package array_west_feeder_pkg;

   localparam logic [1:0] INST_IDLE = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_EXEC  = 2'd2;
   localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/vec_fifo.sv
// Generic single-clock vector FIFO, power-of-two depth.
// Latency: registered read, data valid the cycle after a pop; no write-to-read bypass.
// Backpressure: full flag; a write while full is dropped without any state change.
module vec_fifo #(
   parameter int width = 32,
   parameter int depth = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [width-1:0] wr_data,
   input  logic             rd_en,
   output logic [width-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int aw = $clog2(depth);
   localparam logic [aw:0] depth_cnt = (aw + 1)'(depth);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [aw:0]      count;
   logic             push;
   logic             pop;

   assign full  = (count == depth_cnt);
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/array_west_feeder.sv
// Feeds row vectors from a FIFO to the array west edge as kernel-load or execute beats.
// Latency: one cycle pop-to-row0; rows skewed by r cycles when FEEDER_SKEW_EN is defined.
// Backpressure: cmd_ready only in IDLE; an empty FIFO inserts bubbles; full flags pushes.
module array_west_feeder
   import array_west_feeder_pkg::*;
#(
   parameter int bw    = 4,
   parameter int row   = 8,
   parameter int col   = 8,
   parameter int depth = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [row*bw-1:0]  wr_data,
   output logic               full,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_op,
   input  logic [7:0]         cmd_len,
   output logic [row*bw-1:0]  out_w,
   output logic [row*2-1:0]   inst_out,
   output logic               busy,
   output logic               done
);

`ifdef FEEDER_SKEW_EN
   localparam int drain_cyc = (row > 1) ? row - 1 : 0;
`else
   localparam int drain_cyc = 0;
`endif
   localparam logic [7:0] col_len    = 8'(col);
   localparam logic [7:0] drain_last = 8'(drain_cyc - 1);

   state_t            state;
   logic [7:0]        beat_cnt;
   logic [7:0]        beat_tgt;
   logic [1:0]        inst0;
   logic [row*bw-1:0] fifo_q;
   logic              fifo_empty;
   logic              act_load;
   logic              act_exec;
   logic [7:0]        cur_tgt;
   logic [7:0]        cur_cnt;
   logic              beat;
   logic              last_beat;

   vec_fifo #(.width(row*bw), .depth(depth)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (beat),
      .rd_data (fifo_q),
      .full    (full),
      .empty   (fifo_empty)
   );

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // The accepting cycle already pops, so the first beat leaves one cycle after acceptance.
   always_comb begin
      act_load = 1'b0;
      act_exec = 1'b0;
      cur_tgt  = beat_tgt;
      cur_cnt  = beat_cnt;
      case (state)
         ST_IDLE: begin
            act_load = cmd_valid && !cmd_op;
            act_exec = cmd_valid && cmd_op && (cmd_len != 8'd0);
            cur_tgt  = cmd_op ? cmd_len : col_len;
            cur_cnt  = 8'd0;
         end
         ST_LOAD: act_load = 1'b1;
         ST_EXEC: act_exec = 1'b1;
         default: ;
      endcase
      beat      = (act_load || act_exec) && !fifo_empty;
      last_beat = beat && (cur_cnt + 8'd1 == cur_tgt);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         beat_cnt <= 8'd0;
         beat_tgt <= 8'd0;
         inst0    <= INST_IDLE;
         done     <= 1'b0;
      end else begin
         done  <= 1'b0;
         inst0 <= beat ? (act_load ? INST_LOAD : INST_EXEC) : INST_IDLE;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  beat_tgt <= cur_tgt;
                  beat_cnt <= beat ? 8'd1 : 8'd0;
                  if (cmd_op && (cmd_len == 8'd0)) done <= 1'b1;
                  else state <= cmd_op ? ST_EXEC : ST_LOAD;
               end
            end
            ST_LOAD, ST_EXEC: begin
               if (beat) beat_cnt <= beat_cnt + 8'd1;
            end
            ST_DRAIN: begin
               if (beat_cnt == drain_last) begin
                  state    <= ST_IDLE;
                  done     <= 1'b1;
                  beat_cnt <= 8'd0;
               end else begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (last_beat) begin
            beat_cnt <= 8'd0;
            if (drain_cyc == 0) begin
               state <= ST_IDLE;
               done  <= 1'b1;
            end else begin
               state <= ST_DRAIN;
            end
         end
      end
   end

   for (genvar r = 0; r < row; r++) begin : g_row
`ifdef FEEDER_SKEW_EN
      if (r == 0) begin : g_head
         assign out_w[0 +: bw]  = fifo_q[0 +: bw];
         assign inst_out[1:0]   = inst0;
      end else begin : g_skew
         logic [bw-1:0] sd [r];
         logic [1:0]    si [r];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < r; i++) begin
                  sd[i] <= '0;
                  si[i] <= INST_IDLE;
               end
            end else begin
               sd[0] <= fifo_q[r*bw +: bw];
               si[0] <= inst0;
               for (int i = 1; i < r; i++) begin
                  sd[i] <= sd[i-1];
                  si[i] <= si[i-1];
               end
            end
         end
         assign out_w[r*bw +: bw]  = sd[r-1];
         assign inst_out[r*2 +: 2] = si[r-1];
      end
`else
      assign out_w[r*bw +: bw]  = fifo_q[r*bw +: bw];
      assign inst_out[r*2 +: 2] = inst0;
`endif
   end

endmodule

// File: tb/tb_array_west_feeder.sv
// Scoreboard bench for array_west_feeder: expected beats (inst, data, cycle) per row
// come from a queue-level model; a negedge monitor pops and compares.
module tb_array_west_feeder;

   localparam int BW    = 4;
   localparam int ROW   = 8;
   localparam int COL   = 8;
   localparam int DEPTH = 16;
`ifdef FEEDER_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif
   localparam int DRAIN = (SKEW != 0 && ROW > 1) ? ROW - 1 : 0;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [ROW*BW-1:0] wr_data;
   logic              full;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_op;
   logic [7:0]        cmd_len;
   logic [ROW*BW-1:0] out_w;
   logic [ROW*2-1:0]  inst_out;
   logic              busy;
   logic              done;

   array_west_feeder #(.bw(BW), .row(ROW), .col(COL), .depth(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .out_w     (out_w),
      .inst_out  (inst_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] inst; logic [BW-1:0] d; int t; } beat_t;
   typedef struct { logic [ROW*BW-1:0] d; int e; } ent_t;

   beat_t      exp_q [ROW][$];
   int         exp_done [$];
   ent_t       mq [$];
   int         pend = 0;
   int         last_t = 0;
   logic [1:0] cur_inst = 2'b00;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [BW-1:0] last_d [ROW];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sb_left();
      int s = 0;
      for (int r = 0; r < ROW; r++) s += exp_q[r].size();
      return s;
   endfunction

   // Beat k pops at the later of: one cycle after the previous beat, one cycle after
   // its entry was written, and the acceptance edge. Row r sees it r*SKEW cycles later.
   task automatic sched();
      while (pend > 0 && mq.size() > 0) begin
         ent_t en = mq.pop_front();
         int t = last_t + 1;
         if (en.e + 1 > t) t = en.e + 1;
         for (int r = 0; r < ROW; r++) begin
            beat_t b;
            b.inst = cur_inst;
            b.d    = en.d[r*BW +: BW];
            b.t    = t + r * SKEW;
            exp_q[r].push_back(b);
         end
         pend--;
         last_t = t;
         if (pend == 0) exp_done.push_back(t + DRAIN);
      end
   endtask

   task automatic push(input logic [ROW*BW-1:0] d);
      ent_t en;
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      en.d = d;
      en.e = cyc;
      if (!(pend == 0 && mq.size() >= DEPTH)) begin
         mq.push_back(en);
         sched();
      end
   endtask

   task automatic issue(input logic op, input logic [7:0] len);
      chk("cmd_ready before command", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      last_t    = cyc - 1;
      cur_inst  = op ? 2'b10 : 2'b01;
      pend      = op ? int'(len) : COL;
      if (pend == 0) exp_done.push_back(cyc);
      else sched();
   endtask

   task automatic wait_idle();
      int k = 0;
      while (k < 500 && (busy || pend != 0 || exp_done.size() != 0 || sb_left() != 0)) begin
         tick();
         k++;
      end
      chk("idle within cycle budget", k < 500, 1);
      chk("busy after completion", busy, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " out_w"}, out_w, 0);
      chk({tag, " inst_out"}, inst_out, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " full"}, full, 0);
      chk({tag, " cmd_ready"}, cmd_ready, 1);
   endtask

   always @(negedge clk) begin : mon
      logic [1:0]    ins;
      logic [BW-1:0] d;
      beat_t         e;
      if (!reset) begin
         for (int r = 0; r < ROW; r++) last_d[r] = '0;
      end else begin
         for (int r = 0; r < ROW; r++) begin
            ins = inst_out[r*2 +: 2];
            d   = out_w[r*BW +: BW];
            if (ins != 2'b00) begin
               if (exp_q[r].size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected beat row %0d: got inst %0d at cycle %0d, expected none", r, ins, cyc);
               end else begin
                  e = exp_q[r].pop_front();
                  chk($sformatf("row %0d beat inst", r), ins, e.inst);
                  chk($sformatf("row %0d beat data", r), d, e.d);
                  chk($sformatf("row %0d beat cycle", r), cyc, e.t);
               end
            end else begin
               chk($sformatf("row %0d data held in bubble", r), d, last_d[r]);
            end
            last_d[r] = d;
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected done: got pulse at cycle %0d, expected none", cyc);
            end else begin
               chk("done cycle", cyc, exp_done.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int pre;
      int n;
      logic       op;
      logic [7:0] len;
      reset     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_len   = 8'd0;
      #1;
      chk_reset_outputs("reset");
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // kernel load with all eight vectors already queued
      for (int i = 0; i < 8; i++) push($urandom);
      issue(1'b0, 8'd0);
      wait_idle();

      // execute of three with one entry, the other two arriving later
      push($urandom);
      issue(1'b1, 8'd3);
      tick();
      tick();
      chk("bubble row0 inst", inst_out[1:0], 0);
      chk("busy during bubble", busy, 1);
      tick();
      tick();
      push($urandom);
      push($urandom);
      wait_idle();

      // zero-length execute
      issue(1'b1, 8'd0);
      chk("busy after zero-length exec", busy, 0);
      wait_idle();

      // overfill: the 17th write is dropped
      for (int i = 1; i <= 17; i++) begin
         push($urandom);
         if (i == 15) chk("full after 15 pushes", full, 0);
         if (i == 16) chk("full after 16 pushes", full, 1);
         if (i == 17) chk("full after dropped push", full, 1);
      end
      issue(1'b0, 8'd5);
      wait_idle();
      chk("full after 8 pops", full, 0);
      issue(1'b1, 8'd8);
      wait_idle();

      // randomized commands with staggered pushes
      for (int k = 0; k < 12; k++) begin
         op  = 1'($urandom_range(0, 1));
         len = 8'($urandom_range(0, 6));
         n   = op ? int'(len) : COL;
         pre = $urandom_range(0, n);
         for (int i = 0; i < pre; i++) push($urandom);
         issue(op, len);
         for (int i = pre; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push($urandom);
         end
         wait_idle();
      end

      // reset in the middle of a five-beat execute
      for (int i = 0; i < 5; i++) push($urandom);
      issue(1'b1, 8'd5);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk_reset_outputs("mid-exec reset");
      pend = 0;
      mq.delete();
      exp_done.delete();
      for (int r = 0; r < ROW; r++) exp_q[r].delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
      issue(1'b1, 8'd1);
      repeat (5) tick();
      chk("busy while fifo empty after reset", busy, 1);
      push($urandom);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
